plat_land_scanner: RTL and testbench
====================================

# plat_land_scanner

Per-frame landing-detection scheduler for the platform generator. On every frame tick it normalises the character's absolute Y into a block base and an in-block offset by repeated subtraction. It then walks the current block's platform table one entry per cycle and reports which platform, if any, the falling character lands on. It sits between the platform ROM outputs and the physics/character controller, and serialises the comparison so the wide platform table is not compared in parallel.

## Interface
- PLAT_NUM, 10, platforms per block (max 15)
- PHY_WIDTH, 14, width of all physical coordinates
- BLOCK_WIDTH, 480, vertical span of one block
- CHAR_W, 16, character hitbox width
- LAND_TOL, 4, vertical landing window above platform top
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse, start a scan
- block_switch  in  1  one-cycle pulse, platform table changed
- char_x  in  PHY_WIDTH  character left edge
- char_y  in  PHY_WIDTH  character feet, absolute Y
- falling  in  1  character vertical velocity is downward
- plat_x_bus / plat_y_bus / plat_len_bus  in  PLAT_NUM*PHY_WIDTH  entry i at [i*PHY_WIDTH +: PHY_WIDTH]; plat_y is relative to block base
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, results updated
- hit  out  1  landing found in last completed scan
- hit_idx  out  4  index of landed platform
- hit_y  out  PHY_WIDTH  absolute Y of landed platform top (base + plat_y)
- overrun  out  1  one-cycle pulse, frame_tick arrived while busy

## Operation
- States: IDLE, NORM, SCAN, DONE.
- IDLE: on frame_tick, latch char_x, char_y->rel_y, falling; base<=0; clear best; go NORM.
- NORM: if rel_y >= BLOCK_WIDTH then rel_y -= BLOCK_WIDTH and base += BLOCK_WIDTH, stay; else idx<=0, go SCAN. NORM lasts q+1 cycles, where q = char_y / BLOCK_WIDTH.
- SCAN: evaluate entry idx; idx++. After idx == PLAT_NUM-1, go DONE.
- Candidate i qualifies when all of these hold:
  - falling is latched high;
  - char_x + CHAR_W > plat_x[i];
  - char_x < plat_x[i] + plat_len[i];
  - plat_y[i] <= rel_y <= plat_y[i] + LAND_TOL.
- Sums are computed in PHY_WIDTH+1 bits; no wrap is allowed.
- Selection: a qualifying candidate replaces best if no best exists or its plat_y > best plat_y. On ties, the lower index wins (strict >).
- DONE: register hit, hit_idx, hit_y from best. If no best, hit=0 and hit_idx/hit_y=0. Assert done for this cycle; go IDLE.
- block_switch while in NORM or SCAN: abort, re-latch inputs from current ports, go NORM (restart). No done pulse is produced for the aborted scan.
- block_switch in IDLE or DONE: ignored.
- frame_tick while busy (NORM/SCAN/DONE): dropped, overrun=1 for that cycle.
- frame_tick and block_switch in the same cycle while busy: restart wins, overrun=1.
- Results hold until the next DONE.

## Timing
- Reset: state=IDLE; busy=0, done=0, hit=0, hit_idx=0, hit_y=0, overrun=0; internal rel_y, base, idx and best are cleared. Reset mid-scan returns to IDLE immediately with no done pulse.
- frame_tick sampled at edge e0 -> enters NORM at e0, SCAN at e0+q+1, DONE at e0+q+1+PLAT_NUM. done is high for the cycle after that edge.
- Example: char_y=500, PLAT_NUM=10: q=1, done high after edge e0+12; rel_y=20, base=480.
- Worst case (char_y = 2^14-1, q=34): 45 cycles, well below one frame.
- Platform buses must be stable from NORM exit through SCAN; block_switch is the only mechanism that tolerates table change.
- busy is registered state decode. done and overrun are registered pulses.

## Test plan
- char_y=20, char_x=405, falling=1, entry 0 = (400,20,8), others non-matching -> done at e0+11, hit=1, hit_idx=0, hit_y=20.
- char_y=982, char_x=60, falling=1, entry 3 = (50,22,80) -> base=960, rel_y=22, done at e0+13, hit=1, hit_idx=3, hit_y=982.
- Entries 2 and 5 both qualify with plat_y 100 and 102, rel_y=103 -> hit_idx=5. Then set both plat_y=100 -> hit_idx=2.
- Same overlap as the first test but falling=0, or char_x=420 just past 400+8 -> hit=0, hit_idx=0, hit_y=0.
- block_switch pulsed 4 cycles into SCAN -> no done at the original time. Restart: done arrives q+1+PLAT_NUM cycles after the switch, using the new table.
- frame_tick pulsed during SCAN -> overrun=1 for exactly one cycle, scan unaffected. Assert rst_n low mid-SCAN -> all outputs 0, busy=0 next cycle.

Source files
------------

// File: rtl/plat_land_scanner.sv
// Per-frame landing scanner: folds absolute char Y into block base + offset, then
// walks the platform table one entry per cycle and reports the highest landing hit.
module plat_land_scanner #(
  parameter int unsigned PLAT_NUM    = 10,
  parameter int unsigned PHY_WIDTH   = 14,
  parameter int unsigned BLOCK_WIDTH = 480,
  parameter int unsigned CHAR_W      = 16,
  parameter int unsigned LAND_TOL    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          block_switch,
  input  logic [PHY_WIDTH-1:0]          char_x,
  input  logic [PHY_WIDTH-1:0]          char_y,
  input  logic                          falling,
  input  logic [PLAT_NUM*PHY_WIDTH-1:0] plat_x_bus,
  input  logic [PLAT_NUM*PHY_WIDTH-1:0] plat_y_bus,
  input  logic [PLAT_NUM*PHY_WIDTH-1:0] plat_len_bus,
  output logic                          busy,
  output logic                          done,
  output logic                          hit,
  output logic [3:0]                    hit_idx,
  output logic [PHY_WIDTH-1:0]          hit_y,
  output logic                          overrun
);

  localparam int unsigned SUM_W = PHY_WIDTH + 1;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned TBL_N = 16;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PLAT_NUM - 1);
  localparam logic [PHY_WIDTH-1:0] BLK      = PHY_WIDTH'(BLOCK_WIDTH);

  typedef enum logic [1:0] {IDLE, NORM, SCAN, DONE} state_t;

  state_t               state;
  logic [PHY_WIDTH-1:0] lat_x;
  logic                 lat_fall;
  logic [PHY_WIDTH-1:0] rel_y;
  logic [PHY_WIDTH-1:0] base;
  logic [IDX_W-1:0]     idx;
  logic                 best_vld;
  logic [IDX_W-1:0]     best_idx;
  logic [PHY_WIDTH-1:0] best_py;

  logic [PHY_WIDTH-1:0] tbl_x   [TBL_N];
  logic [PHY_WIDTH-1:0] tbl_y   [TBL_N];
  logic [PHY_WIDTH-1:0] tbl_len [TBL_N];

  // Unpack the flat buses; slots past PLAT_NUM read as zero and are never indexed.
  for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
    if (i < PLAT_NUM) begin : g_used
      assign tbl_x[i]   = plat_x_bus[i*PHY_WIDTH +: PHY_WIDTH];
      assign tbl_y[i]   = plat_y_bus[i*PHY_WIDTH +: PHY_WIDTH];
      assign tbl_len[i] = plat_len_bus[i*PHY_WIDTH +: PHY_WIDTH];
    end else begin : g_pad
      assign tbl_x[i]   = '0;
      assign tbl_y[i]   = '0;
      assign tbl_len[i] = '0;
    end
  end

  logic [PHY_WIDTH-1:0] cand_x_c;
  logic [PHY_WIDTH-1:0] cand_y_c;
  logic [PHY_WIDTH-1:0] cand_len_c;
  logic                 x_lo_ok_c;
  logic                 x_hi_ok_c;
  logic                 y_ok_c;
  logic                 take_c;
  logic                 start_c;

  // Qualification of the current entry; sums carry one extra bit so they never wrap.
  always_comb begin
    cand_x_c   = tbl_x[idx];
    cand_y_c   = tbl_y[idx];
    cand_len_c = tbl_len[idx];
    x_lo_ok_c  = (SUM_W'(lat_x) + SUM_W'(CHAR_W)) > SUM_W'(cand_x_c);
    x_hi_ok_c  = SUM_W'(lat_x) < (SUM_W'(cand_x_c) + SUM_W'(cand_len_c));
    y_ok_c     = (cand_y_c <= rel_y) &&
                 (SUM_W'(rel_y) <= (SUM_W'(cand_y_c) + SUM_W'(LAND_TOL)));
    take_c     = lat_fall && x_lo_ok_c && x_hi_ok_c && y_ok_c &&
                 (!best_vld || (cand_y_c > best_py));
    start_c    = ((state == IDLE) && frame_tick) ||
                 (((state == NORM) || (state == SCAN)) && block_switch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      hit_idx  <= '0;
      hit_y    <= '0;
      overrun  <= 1'b0;
      lat_x    <= '0;
      lat_fall <= 1'b0;
      rel_y    <= '0;
      base     <= '0;
      idx      <= '0;
      best_vld <= 1'b0;
      best_idx <= '0;
      best_py  <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= (state != IDLE) && frame_tick;
      if (start_c) begin
        // Fresh start or restart after a table change: re-latch from the ports.
        state    <= NORM;
        busy     <= 1'b1;
        lat_x    <= char_x;
        lat_fall <= falling;
        rel_y    <= char_y;
        base     <= '0;
        best_vld <= 1'b0;
        best_idx <= '0;
        best_py  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          NORM: begin
            if (rel_y >= BLK) begin
              rel_y <= rel_y - BLK;
              base  <= base + BLK;
            end else begin
              idx   <= '0;
              state <= SCAN;
            end
          end
          SCAN: begin
            idx <= idx + IDX_W'(1);
            if (take_c) begin
              best_vld <= 1'b1;
              best_idx <= idx;
              best_py  <= cand_y_c;
            end
            // Last entry folds straight into the result registers.
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
              if (take_c) begin
                hit     <= 1'b1;
                hit_idx <= idx;
                hit_y   <= base + cand_y_c;
              end else if (best_vld) begin
                hit     <= 1'b1;
                hit_idx <= best_idx;
                hit_y   <= base + best_py;
              end else begin
                hit     <= 1'b0;
                hit_idx <= '0;
                hit_y   <= '0;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plat_land_scanner.sv
// Scoreboard bench for plat_land_scanner: directed cases plus randomized scans
// checked against a plain-arithmetic landing model.
module tb_plat_land_scanner;

  localparam int PN = 10;
  localparam int PW = 14;
  localparam int BW = 480;
  localparam int CW = 16;
  localparam int TOL = 4;

  typedef struct {
    int due;
    int hit;
    int idx;
    int y;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_tick = 1'b0;
  logic              block_switch = 1'b0;
  logic [PW-1:0]     char_x = '0;
  logic [PW-1:0]     char_y = '0;
  logic              falling = 1'b0;
  logic [PN*PW-1:0]  plat_x_bus;
  logic [PN*PW-1:0]  plat_y_bus;
  logic [PN*PW-1:0]  plat_len_bus;
  logic              busy;
  logic              done;
  logic              hit;
  logic [3:0]        hit_idx;
  logic [PW-1:0]     hit_y;
  logic              overrun;

  int px [PN];
  int py [PN];
  int pl [PN];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  plat_land_scanner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .block_switch (block_switch),
    .char_x       (char_x),
    .char_y       (char_y),
    .falling      (falling),
    .plat_x_bus   (plat_x_bus),
    .plat_y_bus   (plat_y_bus),
    .plat_len_bus (plat_len_bus),
    .busy         (busy),
    .done         (done),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .hit_y        (hit_y),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    plat_x_bus   = '0;
    plat_y_bus   = '0;
    plat_len_bus = '0;
    for (int i = 0; i < PN; i++) begin
      plat_x_bus[i*PW +: PW]   = PW'(px[i]);
      plat_y_bus[i*PW +: PW]   = PW'(py[i]);
      plat_len_bus[i*PW +: PW] = PW'(pl[i]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.due);
        chk("hit", int'(hit), mon_e.hit);
        chk("hit_idx", int'(hit_idx), mon_e.idx);
        chk("hit_y", int'(hit_y), mon_e.y);
      end
    end
  end

  function automatic exp_t mk(input int h, input int i, input int y);
    exp_t e;
    e.due = 0;
    e.hit = h;
    e.idx = i;
    e.y   = y;
    return e;
  endfunction

  // Reference: fold Y with div/mod, then pick the highest qualifying top, lowest index on ties.
  function automatic exp_t model(input int cx, input int cy, input bit fall);
    exp_t e;
    int   rel;
    int   base;
    bit   bv;
    bit   q;
    int   bi;
    int   by;
    rel  = cy % BW;
    base = cy - rel;
    bv   = 1'b0;
    bi   = 0;
    by   = 0;
    for (int i = 0; i < PN; i++) begin
      q = fall && (cx + CW > px[i]) && (cx < px[i] + pl[i]) &&
          (py[i] <= rel) && (rel <= py[i] + TOL);
      if (q && (!bv || py[i] > by)) begin
        bv = 1'b1;
        bi = i;
        by = py[i];
      end
    end
    e = mk(bv ? 1 : 0, bv ? bi : 0, bv ? ((base + by) % (1 << PW)) : 0);
    return e;
  endfunction

  function automatic int latency(input int cy);
    return cy / BW + 1 + PN;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < PN; i++) begin
      px[i] = 8000;
      py[i] = 0;
      pl[i] = 1;
    end
  endtask

  task automatic rand_table(input int cx, input int rel);
    int d;
    for (int i = 0; i < PN; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        px[i] = int'($urandom_range(0, 16383));
        py[i] = int'($urandom_range(0, 479));
        pl[i] = int'($urandom_range(1, 64));
      end else begin
        d     = int'($urandom_range(0, 50)) - 30;
        px[i] = (cx + d < 0) ? 0 : ((cx + d > 16383) ? 16383 : cx + d);
        d     = rel - int'($urandom_range(0, 6));
        py[i] = (d < 0) ? 0 : d;
        pl[i] = int'($urandom_range(1, 40));
      end
    end
  endtask

  // Pulse frame_tick for one edge (e0); optionally queue the expected result.
  task automatic start_scan(input int cx, input int cy, input bit fall, input bit push,
                            input exp_t e, output int e0);
    exp_t ex;
    @(posedge clk);
    #1;
    char_x     = PW'(cx);
    char_y     = PW'(cy);
    falling    = fall;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    e0 = cyc;
    chk("busy_after_tick", int'(busy), 1);
    if (push) begin
      ex     = e;
      ex.due = e0 + latency(cy);
      sb.push_back(ex);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    chk("scan_completes", int'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int es;
    int cx;
    int cy;
    bit fall;
    exp_t e;

    clear_table();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_idx", int'(hit_idx), 0);
    chk("rst_hit_y", int'(hit_y), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single platform directly under the feet, block 0.
    clear_table();
    px[0] = 400; py[0] = 20; pl[0] = 8;
    start_scan(405, 20, 1'b1, 1'b1, mk(1, 0, 20), e0);
    wait_idle();

    // Second block: base 960, offset 22.
    clear_table();
    px[3] = 50; py[3] = 22; pl[3] = 80;
    start_scan(60, 982, 1'b1, 1'b1, mk(1, 3, 982), e0);
    wait_idle();

    // Two qualifiers: higher top wins, then equal tops -> lower index.
    clear_table();
    px[2] = 190; py[2] = 100; pl[2] = 20;
    px[5] = 190; py[5] = 102; pl[5] = 20;
    start_scan(200, 103, 1'b1, 1'b1, mk(1, 5, 102), e0);
    wait_idle();
    py[5] = 100;
    start_scan(200, 103, 1'b1, 1'b1, mk(1, 2, 100), e0);
    wait_idle();

    // Misses: not falling, and char_x just past the platform's right edge.
    clear_table();
    px[0] = 400; py[0] = 20; pl[0] = 8;
    start_scan(405, 20, 1'b0, 1'b1, mk(0, 0, 0), e0);
    wait_idle();
    start_scan(420, 20, 1'b1, 1'b1, mk(0, 0, 0), e0);
    wait_idle();
    start_scan(408, 20, 1'b1, 1'b1, mk(0, 0, 0), e0);
    wait_idle();
    start_scan(384, 24, 1'b1, 1'b1, mk(0, 0, 0), e0);
    wait_idle();
    start_scan(385, 24, 1'b1, 1'b1, mk(1, 0, 20), e0);
    wait_idle();

    // Restart 4 cycles into SCAN with a new table; coincident frame_tick flags overrun.
    start_scan(405, 20, 1'b1, 1'b0, mk(0, 0, 0), e0);
    while (cyc < e0 + 4) begin
      @(posedge clk);
      #1;
    end
    clear_table();
    px[3] = 50; py[3] = 22; pl[3] = 80;
    char_x       = PW'(60);
    char_y       = PW'(982);
    falling      = 1'b1;
    block_switch = 1'b1;
    frame_tick   = 1'b1;
    @(posedge clk);
    #1;
    block_switch = 1'b0;
    frame_tick   = 1'b0;
    es = cyc;
    e = mk(1, 3, 982);
    e.due = es + latency(982);
    sb.push_back(e);
    @(negedge clk);
    chk("overrun_on_restart", int'(overrun), 1);
    wait_idle();

    // frame_tick during SCAN: one-cycle overrun, scan result unchanged.
    start_scan(60, 982, 1'b1, 1'b1, mk(1, 3, 982), e0);
    repeat (6) @(posedge clk);
    #1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    @(negedge clk);
    chk("overrun_pulse", int'(overrun), 1);
    @(negedge clk);
    chk("overrun_clears", int'(overrun), 0);
    wait_idle();

    // Reset mid-SCAN: outputs clear at once and no done ever follows.
    start_scan(60, 5000, 1'b1, 1'b0, mk(0, 0, 0), e0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_hit", int'(hit), 0);
    chk("midrst_hit_idx", int'(hit_idx), 0);
    chk("midrst_hit_y", int'(hit_y), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_idle", int'(busy), 0);

    // Randomized scans against the reference model.
    for (int t = 0; t < 40; t++) begin
      cy   = int'($urandom_range(0, 16383));
      cx   = int'($urandom_range(0, 16000));
      fall = ($urandom_range(0, 3) != 0);
      rand_table(cx, cy % BW);
      start_scan(cx, cy, fall, 1'b1, model(cx, cy, fall), e0);
      wait_idle();
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
